// File: rtl/nios_mul_pipe.sv
// Three-stage pipelined DATA_W x DATA_W integer multiplier (MUL, MULXSS, MULXSU, MULXUU)
// built from four unsigned half-width partial products plus a high-word sign correction.
module nios_mul_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int H  = DATA_W / 2;
    localparam int PW = 2 * DATA_W;

    logic advance;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_ll_q, s2_ll_d, s2_lh_q, s2_lh_d;
    logic [DATA_W-1:0] s2_hl_q, s2_hl_d, s2_hh_q, s2_hh_d;
    logic [DATA_W-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic              s2_sa_q, s2_sa_d, s2_sb_q, s2_sb_d;
    logic              s2_lo_q, s2_lo_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

    logic              s3_valid_q, s3_valid_d;
    logic [DATA_W-1:0] s3_result_q, s3_result_d;
    logic [TAG_W-1:0]  s3_tag_q, s3_tag_d;

    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] prod_hi;

    function automatic logic [DATA_W-1:0] pp(input logic [H-1:0] x, input logic [H-1:0] y);
        return {{H{1'b0}}, x} * {{H{1'b0}}, y};
    endfunction

    // The whole pipe moves in lockstep; bubbles are only squeezed out by consumption.
    assign advance    = ~s3_valid_q | out_ready;
    assign in_ready   = advance;
    assign out_valid  = s3_valid_q;
    assign out_result = s3_result_q;
    assign out_tag    = s3_tag_q;

    always_comb begin
        prod = {{DATA_W{1'b0}}, s2_ll_q}
             + ({{DATA_W{1'b0}}, s2_lh_q} << H)
             + ({{DATA_W{1'b0}}, s2_hl_q} << H)
             + {s2_hh_q, {DATA_W{1'b0}}};
        // Signed operands only change the upper word: subtract the other operand there.
        prod_hi = prod[PW-1:DATA_W]
                - (s2_sa_q ? s2_b_q : {DATA_W{1'b0}})
                - (s2_sb_q ? s2_a_q : {DATA_W{1'b0}});
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_mode_d   = s1_mode_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_ll_d     = s2_ll_q;
        s2_lh_d     = s2_lh_q;
        s2_hl_d     = s2_hl_q;
        s2_hh_d     = s2_hh_q;
        s2_a_d      = s2_a_q;
        s2_b_d      = s2_b_q;
        s2_sa_d     = s2_sa_q;
        s2_sb_d     = s2_sb_q;
        s2_lo_d     = s2_lo_q;
        s2_tag_d    = s2_tag_q;
        s3_valid_d  = s3_valid_q;
        s3_result_d = s3_result_q;
        s3_tag_d    = s3_tag_q;
        if (advance) begin
            s1_valid_d  = in_valid;
            s1_a_d      = in_src1;
            s1_b_d      = in_src2;
            s1_mode_d   = in_mode;
            s1_tag_d    = in_tag;

            s2_valid_d  = s1_valid_q;
            s2_ll_d     = pp(s1_a_q[H-1:0],      s1_b_q[H-1:0]);
            s2_lh_d     = pp(s1_a_q[H-1:0],      s1_b_q[DATA_W-1:H]);
            s2_hl_d     = pp(s1_a_q[DATA_W-1:H], s1_b_q[H-1:0]);
            s2_hh_d     = pp(s1_a_q[DATA_W-1:H], s1_b_q[DATA_W-1:H]);
            s2_a_d      = s1_a_q;
            s2_b_d      = s1_b_q;
            s2_sa_d     = s1_a_q[DATA_W-1] & ((s1_mode_q == 2'b01) | (s1_mode_q == 2'b10));
            s2_sb_d     = s1_b_q[DATA_W-1] & (s1_mode_q == 2'b01);
            s2_lo_d     = (s1_mode_q == 2'b00);
            s2_tag_d    = s1_tag_q;

            s3_valid_d  = s2_valid_q;
            s3_result_d = s2_lo_q ? prod[DATA_W-1:0] : prod_hi;
            s3_tag_d    = s2_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_ll_q     <= '0;
            s2_lh_q     <= '0;
            s2_hl_q     <= '0;
            s2_hh_q     <= '0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            s2_sa_q     <= 1'b0;
            s2_sb_q     <= 1'b0;
            s2_lo_q     <= 1'b0;
            s2_tag_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_result_q <= '0;
            s3_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_ll_q     <= s2_ll_d;
            s2_lh_q     <= s2_lh_d;
            s2_hl_q     <= s2_hl_d;
            s2_hh_q     <= s2_hh_d;
            s2_a_q      <= s2_a_d;
            s2_b_q      <= s2_b_d;
            s2_sa_q     <= s2_sa_d;
            s2_sb_q     <= s2_sb_d;
            s2_lo_q     <= s2_lo_d;
            s2_tag_q    <= s2_tag_d;
            s3_valid_q  <= s3_valid_d;
            s3_result_q <= s3_result_d;
            s3_tag_q    <= s3_tag_d;
        end
    end
endmodule

// File: tb/tb_nios_mul_pipe.sv
// Bench for nios_mul_pipe: directed mode/sign/backpressure/reset cases plus random traffic
// at DATA_W=32 and DATA_W=8, scored against a signed/unsigned arithmetic reference.
module tb_nios_mul_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_mode;
    logic [31:0] a_src1, a_src2, a_res;
    logic [4:0]  a_tag, a_otag;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0]  b_mode;
    logic [7:0]  b_src1, b_src2, b_res;
    logic [4:0]  b_tag, b_otag;

    nios_mul_pipe #(.DATA_W(32), .TAG_W(5)) dut_a (
        .clk(clk), .reset(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_mode), .in_src1(a_src1), .in_src2(a_src2), .in_tag(a_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_res), .out_tag(a_otag));

    nios_mul_pipe #(.DATA_W(8), .TAG_W(5)) dut_b (
        .clk(clk), .reset(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_mode), .in_src1(b_src1), .in_src2(b_src2), .in_tag(b_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_res), .out_tag(b_otag));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nb_cons = 0;
    bit mon_en = 1'b0;

    typedef struct {longint unsigned res; int tag; int acc;} ent_t;
    ent_t qa[$], qb[$], la[$];
    ent_t a_e, b_e;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Reference: interpret operands as signed/unsigned integers, multiply exactly, pick a word.
    function automatic longint unsigned ref_mul(input int w, input logic [1:0] m,
                                                input longint unsigned x, input longint unsigned y);
        longint signed xs, ys, p;
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        xs = longint'(x);
        ys = longint'(y);
        if ((m == 2'd1 || m == 2'd2) && x[w-1]) xs = xs - longint'(64'd1 << w);
        if (m == 2'd1 && y[w-1]) ys = ys - longint'(64'd1 << w);
        p = xs * ys;
        if (m == 2'd0) return longint'(p) & mask;
        return (longint'(p) >> w) & mask;
    endfunction

    function automatic longint unsigned rand_op(input int w);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return mask;
            2: return 64'd1 << (w - 1);
            3: return (64'd1 << (w - 1)) - 64'd1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    logic [31:0] a_hres;
    logic [4:0]  a_htag;
    bit          a_hold = 1'b0;
    always @(negedge clk) if (mon_en) begin
        check("a_in_ready_rule", a_in_ready, (!a_out_valid || a_out_ready));
        if (a_hold) begin
            check("a_hold_res", a_res, a_hres);
            check("a_hold_tag", a_otag, a_htag);
        end
        if (a_out_valid) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_spurious got tag=%0d res=0x%0h exp=no_result", a_otag, a_res);
            end else begin
                check("a_res", a_res, qa[0].res);
                check("a_tag", a_otag, qa[0].tag);
                if (a_out_ready) begin
                    a_e = qa.pop_front();
                    a_e.acc = cyc - a_e.acc;
                    la.push_back(a_e);
                end
            end
        end
        a_hold = a_out_valid && !a_out_ready;
        a_hres = a_res;
        a_htag = a_otag;
        if (rst) begin
            qa.delete();
            a_hold = 1'b0;
        end else if (a_in_valid && a_in_ready)
            qa.push_back('{ref_mul(32, a_mode, a_src1, a_src2), int'(a_tag), cyc});
    end

    logic [7:0] b_hres;
    logic [4:0] b_htag;
    bit         b_hold = 1'b0;
    always @(negedge clk) if (mon_en) begin
        check("b_in_ready_rule", b_in_ready, (!b_out_valid || b_out_ready));
        if (b_hold) begin
            check("b_hold_res", b_res, b_hres);
            check("b_hold_tag", b_otag, b_htag);
        end
        if (b_out_valid) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_spurious got tag=%0d res=0x%0h exp=no_result", b_otag, b_res);
            end else begin
                check("b_res", b_res, qb[0].res);
                check("b_tag", b_otag, qb[0].tag);
                if (b_out_ready) begin
                    b_e = qb.pop_front();
                    nb_cons++;
                end
            end
        end
        b_hold = b_out_valid && !b_out_ready;
        b_hres = b_res;
        b_htag = b_otag;
        if (rst) begin
            qb.delete();
            b_hold = 1'b0;
        end else if (b_in_valid && b_in_ready)
            qb.push_back('{ref_mul(8, b_mode, b_src1, b_src2), int'(b_tag), cyc});
    end

    task automatic send_a(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] t);
        a_in_valid = 1'b1; a_mode = m; a_src1 = x; a_src2 = y; a_tag = t;
        for (int i = 0; i <= 64; i++) begin
            @(negedge clk);
            if (a_in_ready) break;
            if (i == 64) begin
                checks++; failures++;
                $display("FAIL a_send_timeout got in_ready=0 exp=1");
            end
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic check_log(input string nm, input int n, input longint unsigned er[6],
                             input int et[6], input bit lat);
        for (int i = 0; i < 100 && la.size() < n; i++) @(negedge clk);
        check({nm, "_count"}, la.size(), n);
        if (la.size() == n)
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_res%0d", nm, i), la[i].res, er[i]);
                check($sformatf("%s_tag%0d", nm, i), la[i].tag, et[i]);
                if (lat) check($sformatf("%s_latency%0d", nm, i), la[i].acc, 3);
            end
        @(posedge clk); #1;
    endtask

    task automatic rand_a(input int n);
        int p;
        for (int i = 0; i < n; i++) begin
            p = 3 + 3 * ((i / 500) % 3);
            a_in_valid  = ($urandom_range(0, 9) < p);
            a_mode      = 2'($urandom_range(0, 3));
            a_src1      = 32'(rand_op(32));
            a_src2      = 32'(rand_op(32));
            a_tag       = 5'(i);
            a_out_ready = ($urandom_range(0, 9) < 10 - p + 2);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
    endtask

    task automatic rand_b(input int n);
        int p;
        for (int i = 0; i < n; i++) begin
            p = 4 + 3 * ((i / 700) % 3);
            b_in_valid  = ($urandom_range(0, 9) < p);
            b_mode      = 2'($urandom_range(0, 3));
            b_src1      = 8'(rand_op(8));
            b_src2      = 8'(rand_op(8));
            b_tag       = 5'(i);
            b_out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_mode = '0; a_src1 = '0; a_src2 = '0; a_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_mode = '0; b_src1 = '0; b_src2 = '0; b_tag = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_a_result", a_res, 0);
        check("rst_a_tag", a_otag, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_result", b_res, 0);

        check("pin_ref_mul_ff", ref_mul(32, 2'd0, 64'hFFFFFFFF, 64'hFFFFFFFF), 64'h1);
        check("pin_ref_mulxuu_ff", ref_mul(32, 2'd3, 64'hFFFFFFFF, 64'hFFFFFFFF), 64'hFFFFFFFE);
        check("pin_ref_mulxss_80", ref_mul(8, 2'd1, 64'h80, 64'h80), 64'h40);
        check("pin_ref_mulxsu_m1x2", ref_mul(8, 2'd2, 64'hFF, 64'h02), 64'hFF);
        mon_en = 1'b1;
        @(posedge clk); #1;

        la.delete();
        send_a(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
        send_a(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
        send_a(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
        send_a(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        check_log("modes", 4, '{64'h1, 64'h0, 64'hFFFFFFFF, 64'hFFFFFFFE, 64'h0, 64'h0},
                  '{1, 2, 3, 4, 0, 0}, 1'b1);

        la.delete();
        send_a(2'd1, 32'h80000000, 32'h80000000, 5'd5);
        send_a(2'd2, 32'h80000000, 32'h80000000, 5'd6);
        send_a(2'd3, 32'h80000000, 32'h80000000, 5'd7);
        send_a(2'd0, 32'h80000000, 32'h80000000, 5'd8);
        check_log("sign", 4, '{64'h40000000, 64'hC0000000, 64'h40000000, 64'h0, 64'h0, 64'h0},
                  '{5, 6, 7, 8, 0, 0}, 1'b1);

        la.delete();
        a_out_ready = 1'b0;
        fork
            for (int k = 1; k <= 6; k++) send_a(2'd0, 32'(k), 32'd3, 5'(k));
            begin
                for (int i = 0; i < 40 && !a_out_valid; i++) @(negedge clk);
                for (int j = 0; j < 4; j++) begin
                    check("bp_out_valid", a_out_valid, 1);
                    check("bp_in_ready", a_in_ready, 0);
                    check("bp_res", a_res, 3);
                    check("bp_tag", a_otag, 1);
                    if (j < 3) @(negedge clk);
                end
                @(posedge clk); #1;
                a_out_ready = 1'b1;
            end
        join
        check_log("bp", 6, '{64'd3, 64'd6, 64'd9, 64'd12, 64'd15, 64'd18},
                  '{1, 2, 3, 4, 5, 6}, 1'b0);

        la.delete();
        a_out_ready = 1'b0;
        send_a(2'd0, 32'd1, 32'd1, 5'd10);
        send_a(2'd0, 32'd2, 32'd1, 5'd11);
        send_a(2'd0, 32'd3, 32'd1, 5'd12);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_flush_out_valid", a_out_valid, 0);
        end
        check("rst_flush_none_consumed", la.size(), 0);
        @(posedge clk); #1;
        send_a(2'd0, 32'd7, 32'd6, 5'd13);
        check_log("rst_new", 1, '{64'd42, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0},
                  '{13, 0, 0, 0, 0, 0}, 1'b1);

        la.delete();
        nb_cons = 0;
        fork
            rand_a(6000);
            rand_b(6000);
        join
        for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        check("a_drain_empty", qa.size(), 0);
        check("b_drain_empty", qb.size(), 0);
        check("a_rand_volume", (la.size() > 1500), 1);
        check("b_rand_volume", (nb_cons > 1500), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
